// File: rtl/proc_pkg.sv
// Shared processor constants and types for the register file slice.
package proc_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   function automatic logic addr_in_range(reg_addr_t a, int unsigned n);
      return 32'(a) < n;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/issue/writeback signal bundle between the pipeline and the register file.
interface regfile_if #(
   parameter int unsigned XLEN = proc_pkg::XLEN
);
   logic                 rd_en_i;
   proc_pkg::reg_addr_t  rd1_addr_i;
   proc_pkg::reg_addr_t  rd2_addr_i;
   logic [XLEN-1:0]      rd1_data_o;
   logic [XLEN-1:0]      rd2_data_o;
   logic                 iss_valid_i;
   proc_pkg::reg_addr_t  iss_rd_addr_i;
   logic                 wb_en_i;
   proc_pkg::reg_addr_t  wb_addr_i;
   logic [XLEN-1:0]      wb_data_i;
   logic                 stall_o;

   modport slave (
      input  rd_en_i, rd1_addr_i, rd2_addr_i,
      input  iss_valid_i, iss_rd_addr_i,
      input  wb_en_i, wb_addr_i, wb_data_i,
      output rd1_data_o, rd2_data_o, stall_o
   );

   modport master (
      output rd_en_i, rd1_addr_i, rd2_addr_i,
      output iss_valid_i, iss_rd_addr_i,
      output wb_en_i, wb_addr_i, wb_data_i,
      input  rd1_data_o, rd2_data_o, stall_o
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking in-flight destinations; produces the RAW/WAW stall.
module regfile_scoreboard
   import proc_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   input  logic      rd_en_i,
   input  reg_addr_t rs1_addr_i,
   input  reg_addr_t rs2_addr_i,
   input  logic      iss_valid_i,
   input  reg_addr_t iss_rd_addr_i,
   input  logic      wb_en_i,
   input  reg_addr_t wb_addr_i,
   output logic      rs1_busy_o,
   output logic      rs2_busy_o,
   output logic      iss_busy_o,
   output logic      stall_o
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // A register being written back this cycle no longer blocks its readers.
   always_comb begin
      rs1_busy_o = busy_q[rs1_addr_i]    && !(wb_en_i && (wb_addr_i == rs1_addr_i));
      rs2_busy_o = busy_q[rs2_addr_i]    && !(wb_en_i && (wb_addr_i == rs2_addr_i));
      iss_busy_o = busy_q[iss_rd_addr_i] && !(wb_en_i && (wb_addr_i == iss_rd_addr_i));
      stall_o    = (rd_en_i && (rs1_busy_o || rs2_busy_o)) || (iss_valid_i && iss_busy_o);
   end

   // Set is applied after clear so a same-cycle issue wins over the writeback.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (wb_en_i && (wb_addr_i == REG_ADDR_W'(i)))
            busy_d[i] = 1'b0;
         if (iss_valid_i && !stall_o && (iss_rd_addr_i == REG_ADDR_W'(i)))
            busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

endmodule

// File: rtl/regfile.sv
// Integer register file: 2 registered read ports with writeback bypass, 1 write port, hazard scoreboard.
module regfile #(
   parameter int unsigned XLEN     = proc_pkg::XLEN,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   regfile_if.slave  bus
);
   import proc_pkg::*;

   logic [XLEN-1:0] mem_q [NUM_REGS];
   logic [XLEN-1:0] rd1_q, rd1_d;
   logic [XLEN-1:0] rd2_q, rd2_d;
   logic            stall;
   logic            rs1_busy, rs2_busy, iss_busy;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .rd_en_i       (bus.rd_en_i),
      .rs1_addr_i    (bus.rd1_addr_i),
      .rs2_addr_i    (bus.rd2_addr_i),
      .iss_valid_i   (bus.iss_valid_i),
      .iss_rd_addr_i (bus.iss_rd_addr_i),
      .wb_en_i       (bus.wb_en_i),
      .wb_addr_i     (bus.wb_addr_i),
      .rs1_busy_o    (rs1_busy),
      .rs2_busy_o    (rs2_busy),
      .iss_busy_o    (iss_busy),
      .stall_o       (stall)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            mem_q[i] <= '0;
      end else if (bus.wb_en_i && (bus.wb_addr_i != '0)) begin
         mem_q[bus.wb_addr_i] <= bus.wb_data_i;
      end
   end

   // x0 is forced to zero at the read mux so a bypassed x0 write can never leak out.
   always_comb begin
      rd1_d = rd1_q;
      rd2_d = rd2_q;
      if (bus.rd_en_i && !stall) begin
         if (bus.rd1_addr_i == '0)
            rd1_d = '0;
         else if (bus.wb_en_i && (bus.wb_addr_i == bus.rd1_addr_i))
            rd1_d = bus.wb_data_i;
         else
            rd1_d = mem_q[bus.rd1_addr_i];

         if (bus.rd2_addr_i == '0)
            rd2_d = '0;
         else if (bus.wb_en_i && (bus.wb_addr_i == bus.rd2_addr_i))
            rd2_d = bus.wb_data_i;
         else
            rd2_d = mem_q[bus.rd2_addr_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd1_q <= '0;
         rd2_q <= '0;
      end else begin
         rd1_q <= rd1_d;
         rd2_q <= rd2_d;
      end
   end

   assign bus.rd1_data_o = rd1_q;
   assign bus.rd2_data_o = rd2_q;
   assign bus.stall_o    = stall;

   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         if (bus.rd_en_i) begin
            assert (addr_in_range(bus.rd1_addr_i, NUM_REGS));
            assert (addr_in_range(bus.rd2_addr_i, NUM_REGS));
         end
         if (bus.iss_valid_i)
            assert (addr_in_range(bus.iss_rd_addr_i, NUM_REGS));
         if (bus.wb_en_i)
            assert (addr_in_range(bus.wb_addr_i, NUM_REGS));
         assert (stall == ((bus.rd_en_i && (rs1_busy || rs2_busy)) ||
                           (bus.iss_valid_i && iss_busy)));
      end
   end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter XLEN, default 32: register data width.
REQ-002 Parameter NUM_REGS, default 32: architectural register count; x0 is included.
REQ-003 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-005 Port rd_en_i, input, 1: decode-stage read request valid.
REQ-006 Port rd1_addr_i, input, 5: source register 1 index.
REQ-007 Port rd2_addr_i, input, 5: source register 2 index.
REQ-008 Port rd1_data_o, output, XLEN: registered rs1 data; feeds the execute operand-1 mux.
REQ-009 Port rd2_data_o, output, XLEN: registered rs2 data; feeds the execute operand-2 mux.
REQ-010 Port iss_valid_i, input, 1: an instruction with a destination register issues this cycle.
REQ-011 Port iss_rd_addr_i, input, 5: destination index of the issuing instruction.
REQ-012 Port wb_en_i, input, 1: writeback valid from the W-stage mux.
REQ-013 Port wb_addr_i, input, 5: writeback destination index.
REQ-014 Port wb_data_i, input, XLEN: writeback data.
REQ-015 Port stall_o, output, 1: combinational hazard stall to decode.

Function
REQ-016 Writes: register wb_addr_i SHALL take wb_data_i on the edge where wb_en_i=1 and wb_addr_i!=0.
REQ-017 x0: reads of x0 SHALL always return 0, and writes to x0 SHALL be discarded.
REQ-018 Read latency: when rd_en_i=1 and stall_o=0, rdN_data_o SHALL show register rdN_addr_i one cycle later (1-cycle latency).
REQ-019 Hold: when rd_en_i=0 or stall_o=1, rdN_data_o SHALL hold their previous values.
REQ-020 Bypass: when wb_en_i=1 and wb_addr_i equals rdN_addr_i (nonzero) in the same cycle, rdN_data_o SHALL capture wb_data_i instead of the old array value.
REQ-021 Scoreboard: each register 1..NUM_REGS-1 SHALL have a busy bit; bit 0 SHALL be constant 0.
REQ-022 Busy set: the busy bit of iss_rd_addr_i SHALL be set on the edge where iss_valid_i=1, stall_o=0 and iss_rd_addr_i!=0.
REQ-023 Busy clear: the busy bit of wb_addr_i SHALL be cleared on the edge where wb_en_i=1.
REQ-024 Same-cycle issue and writeback to one register: set SHALL win, so the busy bit stays 1.
REQ-025 Effective busy: a register SHALL count as effectively busy when its busy bit is 1 and it is not being written back this cycle (wb_en_i=1 with wb_addr_i matching).
REQ-026 stall_o SHALL be 1 when either condition holds:
 - RAW: rd_en_i=1 and rd1_addr_i or rd2_addr_i is effectively busy.
 - WAW: iss_valid_i=1 and iss_rd_addr_i is effectively busy.
REQ-027 stall_o SHALL be 0 otherwise.
REQ-028 Issue gating: while stall_o=1, the issue SHALL be ignored and the scoreboard SHALL not change, except for writeback clears.
REQ-029 Address width: indices are 5 bits wide; indices >= NUM_REGS are illegal and SHALL be excluded by assertion.

Reset
REQ-030 While rst_n_i=0:
 - all array registers SHALL be 0;
 - all busy bits SHALL be 0;
 - rd1_data_o and rd2_data_o SHALL be 0.
REQ-031 stall_o SHALL be 0 after reset, with no pending issues.
REQ-032 Assertion of rst_n_i mid-operation SHALL clear pending busy bits immediately, without waiting for a clock edge.
REQ-033 A writeback presented on the first edge after reset deassertion SHALL be honoured.

Structure
REQ-034 proc_pkg SHALL hold the shared constants XLEN and REG_ADDR_W=5.
REQ-035 proc_pkg SHALL hold typedef reg_addr_t, sized by REG_ADDR_W.
REQ-036 The busy-bit logic SHALL live in sub-module regfile_scoreboard, which exposes effective-busy lookups for three addresses and stall_o.
REQ-037 The storage array and read registers SHALL stay in regfile.

Verification
REQ-038 RAW stall: write x5=0x0000_00A5, read x5 next cycle -> rd1_data_o=0x0000_00A5 one cycle after the request.
REQ-039 x0: write x0=0xFFFF_FFFF, then read x0 -> rd1_data_o=0 and rd2_data_o=0.
REQ-040 Bypass: same cycle wb_en_i=1, wb_addr_i=7, wb_data_i=0x1234_5678 and rd2_addr_i=7 -> next cycle rd2_data_o=0x1234_5678.
REQ-041 Hazard:
 - Stimulus: issue rd=3, then read rs1=3.
 - Response: stall_o=1 and rd1_data_o held until wb_en_i=1 with wb_addr_i=3.
 - Release: in that writeback cycle stall_o=0 and the bypassed data is captured.
REQ-042 Issue/writeback collision: issue rd=9 while a writeback to 9 occurs -> busy[9] stays 1, and a later read of 9 stalls.
REQ-043 Mid-op reset:
 - Stimulus: busy[4]=1 with rd1_data_o nonzero, then assert rst_n_i between edges.
 - Response: rd1_data_o=0 and busy cleared immediately.
 - Next: a read of x4 after release returns 0 with no stall.
